// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the single-bus CPU control sequencer: state codes
// (matching the step output), default opcode encodings, and the bundle
// of datapath strobes.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    T0   = 4'd1,
    T1   = 4'd2,
    T2   = 4'd3,
    T3   = 4'd4,
    T4   = 4'd5,
    T5   = 4'd6,
    T6   = 4'd7,
    T7   = 4'd8
  } state_e;

  localparam logic [4:0] OP_LD  = 5'b00000;
  localparam logic [4:0] OP_LDI = 5'b00001;
  localparam logic [4:0] OP_ST  = 5'b00010;

  typedef struct packed {
    logic pc_out;
    logic mar_in;
    logic inc_pc;
    logic z_high_in;
    logic z_low_in;
    logic z_low_out;
    logic pc_in;
    logic read;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic gra;
    logic grb;
    logic ba_out;
    logic y_in;
    logic c_out;
    logic r_in;
    logic r_out;
    logic ram_write_en;
  } ctrl_t;

endpackage

// File: rtl/mem_instr_sequencer_if.sv
// Sequencer <-> decode/datapath bundle.
// master: sequencer side (takes run/stall/opcode, drives strobes and status).
// slave:  decode/datapath side.
interface mem_instr_sequencer_if #(
  parameter int OPC_W = 5
);
  logic             run;
  logic             stall;
  logic [OPC_W-1:0] opcode;
  logic PCout, MARin, IncPC, ZHighIn, ZLowIn, ZLowout, PCin, Read, MDRin;
  logic MDRout, IRin, Gra, Grb, BAout, Yin, Cout, R_in, Rout, RAM_write_en;
  logic [3:0]       step;
  logic             busy;
  logic             instr_done;
  logic             illegal_op;

  modport master (
    input  run, stall, opcode,
    output PCout, MARin, IncPC, ZHighIn, ZLowIn, ZLowout, PCin, Read, MDRin,
           MDRout, IRin, Gra, Grb, BAout, Yin, Cout, R_in, Rout, RAM_write_en,
           step, busy, instr_done, illegal_op
  );

  modport slave (
    output run, stall, opcode,
    input  PCout, MARin, IncPC, ZHighIn, ZLowIn, ZLowout, PCin, Read, MDRin,
           MDRout, IRin, Gra, Grb, BAout, Yin, Cout, R_in, Rout, RAM_write_en,
           step, busy, instr_done, illegal_op
  );
endinterface

// File: rtl/mem_wait_counter.sv
// Memory wait-state counter. load clears to 0, inc advances by one,
// done flags that the final cycle of an access has been reached.
// Ports: clk, clr (sync reset), load, inc, done.
module mem_wait_counter #(
  parameter int WAIT_W   = 4,
  parameter int MEM_WAIT = 0
) (
  input  logic clk,
  input  logic clr,
  input  logic load,
  input  logic inc,
  output logic done
);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)     cnt_d = '0;
    else if (inc) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign done = (cnt_q == WAIT_W'(MEM_WAIT));

endmodule

// File: rtl/mem_instr_sequencer.sv
// Hardwired T-step control generator for fetch + ld/ldi/st.
// Ports: clk, clr (sync active-high reset), bus (master modport: run,
// stall, opcode in; datapath strobes, step, busy, instr_done, illegal_op out).
module mem_instr_sequencer #(
  parameter int               OPC_W    = 5,
  parameter logic [OPC_W-1:0] OP_LD    = OPC_W'(cpu_ctrl_pkg::OP_LD),
  parameter logic [OPC_W-1:0] OP_LDI   = OPC_W'(cpu_ctrl_pkg::OP_LDI),
  parameter logic [OPC_W-1:0] OP_ST    = OPC_W'(cpu_ctrl_pkg::OP_ST),
  parameter int               MEM_WAIT = 0,
  parameter int               WAIT_W   = 4
) (
  input  logic                 clk,
  input  logic                 clr,
  mem_instr_sequencer_if.master bus
);
  import cpu_ctrl_pkg::*;

  state_e           state_q, state_d, fin_state;
  logic [OPC_W-1:0] opc_q, opc_d;
  logic             cnt_done, cnt_load, cnt_inc;
  logic             op_legal, is_ld, is_ldi;
  logic             done_c, illegal_c;
  ctrl_t            ctrl;

  assign op_legal  = (bus.opcode == OP_LD) || (bus.opcode == OP_LDI) || (bus.opcode == OP_ST);
  assign is_ld     = (opc_q == OP_LD);
  assign is_ldi    = (opc_q == OP_LDI);
  assign fin_state = bus.run ? T0 : IDLE;

  // Every state change restarts the count, so each wait state is entered at 0.
  assign cnt_load = (state_d != state_q);
  assign cnt_inc  = !bus.stall && (state_q == T1 || state_q == T6 || state_q == T7);

  mem_wait_counter #(
    .WAIT_W  (WAIT_W),
    .MEM_WAIT(MEM_WAIT)
  ) u_wait (
    .clk (clk),
    .clr (clr),
    .load(cnt_load),
    .inc (cnt_inc),
    .done(cnt_done)
  );

  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    if (!bus.stall) begin
      unique case (state_q)
        IDLE: if (bus.run) state_d = T0;
        T0:   state_d = T1;
        T1:   if (cnt_done) state_d = T2;
        T2:   state_d = T3;
        T3: begin
          opc_d   = bus.opcode;
          state_d = op_legal ? T4 : fin_state;
        end
        T4:   state_d = T5;
        T5:   state_d = is_ldi ? fin_state : T6;
        T6:   if (!is_ld || cnt_done) state_d = T7;
        T7:   if (is_ld || cnt_done) state_d = fin_state;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      opc_q   <= '0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
    end
  end

  always_comb begin
    ctrl      = '0;
    done_c    = 1'b0;
    illegal_c = 1'b0;
    unique case (state_q)
      T0: begin
        ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1; ctrl.inc_pc = 1'b1;
        ctrl.z_high_in = 1'b1; ctrl.z_low_in = 1'b1;
      end
      T1: begin
        ctrl.read = 1'b1;
        if (cnt_done) begin
          ctrl.mdr_in = 1'b1; ctrl.z_low_out = 1'b1; ctrl.pc_in = 1'b1;
        end
      end
      T2: begin
        ctrl.mdr_out = 1'b1; ctrl.ir_in = 1'b1;
      end
      T3: begin
        if (op_legal) begin
          ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1;
        end else begin
          illegal_c = 1'b1;
        end
      end
      T4: begin
        ctrl.c_out = 1'b1; ctrl.z_high_in = 1'b1; ctrl.z_low_in = 1'b1;
      end
      T5: begin
        ctrl.z_low_out = 1'b1;
        if (is_ldi) begin
          ctrl.gra = 1'b1; ctrl.r_in = 1'b1; done_c = 1'b1;
        end else begin
          ctrl.mar_in = 1'b1;
        end
      end
      T6: begin
        if (is_ld) begin
          ctrl.read   = 1'b1;
          ctrl.mdr_in = cnt_done;
        end else begin
          ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.mdr_in = 1'b1;
        end
      end
      T7: begin
        if (is_ld) begin
          ctrl.mdr_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; done_c = 1'b1;
        end else begin
          ctrl.ram_write_en = 1'b1;
          done_c            = cnt_done;
        end
      end
      default: ;
    endcase
    if (bus.stall || state_q == IDLE) begin
      ctrl      = '0;
      done_c    = 1'b0;
      illegal_c = 1'b0;
    end
  end

  assign bus.PCout        = ctrl.pc_out;
  assign bus.MARin        = ctrl.mar_in;
  assign bus.IncPC        = ctrl.inc_pc;
  assign bus.ZHighIn      = ctrl.z_high_in;
  assign bus.ZLowIn       = ctrl.z_low_in;
  assign bus.ZLowout      = ctrl.z_low_out;
  assign bus.PCin         = ctrl.pc_in;
  assign bus.Read         = ctrl.read;
  assign bus.MDRin        = ctrl.mdr_in;
  assign bus.MDRout       = ctrl.mdr_out;
  assign bus.IRin         = ctrl.ir_in;
  assign bus.Gra          = ctrl.gra;
  assign bus.Grb          = ctrl.grb;
  assign bus.BAout        = ctrl.ba_out;
  assign bus.Yin          = ctrl.y_in;
  assign bus.Cout         = ctrl.c_out;
  assign bus.R_in         = ctrl.r_in;
  assign bus.Rout         = ctrl.r_out;
  assign bus.RAM_write_en = ctrl.ram_write_en;
  assign bus.step         = state_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.instr_done   = done_c;
  assign bus.illegal_op   = illegal_c;

endmodule

// File: tb/tb_mem_instr_sequencer.sv
module tb_mem_instr_sequencer;

  localparam int K_LD = 0, K_LDI = 1, K_ST = 2, K_ILL = 3;
  localparam int B_PCOUT = 0, B_MARIN = 1, B_INCPC = 2, B_ZHI = 3, B_ZLI = 4,
                 B_ZLO = 5, B_PCIN = 6, B_READ = 7, B_MDRIN = 8, B_MDROUT = 9,
                 B_IRIN = 10, B_GRA = 11, B_GRB = 12, B_BAOUT = 13, B_YIN = 14,
                 B_COUT = 15, B_RIN = 16, B_ROUT = 17, B_RAM = 18;

  logic       clk = 1'b0;
  logic       clr;
  logic       run_v   [3];
  logic       stall_v [3];
  logic [4:0] opc_v   [3];
  int         sel;
  int         n_run = 0;
  int         n_fail = 0;
  logic [25:0] exp_q [$];
  logic [25:0] plan  [$];
  logic [25:0] obs0, obs1, obs2, obs_sel, e_mon;

  always #5 clk = ~clk;

  mem_instr_sequencer_if #(.OPC_W(5)) bus0 ();
  mem_instr_sequencer_if #(.OPC_W(5)) bus1 ();
  mem_instr_sequencer_if #(.OPC_W(5)) bus2 ();

  assign bus0.run = run_v[0]; assign bus0.stall = stall_v[0]; assign bus0.opcode = opc_v[0];
  assign bus1.run = run_v[1]; assign bus1.stall = stall_v[1]; assign bus1.opcode = opc_v[1];
  assign bus2.run = run_v[2]; assign bus2.stall = stall_v[2]; assign bus2.opcode = opc_v[2];

  mem_instr_sequencer #(.MEM_WAIT(0)) u_w0 (.clk(clk), .clr(clr), .bus(bus0));
  mem_instr_sequencer #(.MEM_WAIT(1)) u_w1 (.clk(clk), .clr(clr), .bus(bus1));
  mem_instr_sequencer #(.MEM_WAIT(2)) u_w2 (.clk(clk), .clr(clr), .bus(bus2));

  assign obs0 = {bus0.step, bus0.busy, bus0.instr_done, bus0.illegal_op,
                 bus0.RAM_write_en, bus0.Rout, bus0.R_in, bus0.Cout, bus0.Yin, bus0.BAout,
                 bus0.Grb, bus0.Gra, bus0.IRin, bus0.MDRout, bus0.MDRin, bus0.Read, bus0.PCin,
                 bus0.ZLowout, bus0.ZLowIn, bus0.ZHighIn, bus0.IncPC, bus0.MARin, bus0.PCout};
  assign obs1 = {bus1.step, bus1.busy, bus1.instr_done, bus1.illegal_op,
                 bus1.RAM_write_en, bus1.Rout, bus1.R_in, bus1.Cout, bus1.Yin, bus1.BAout,
                 bus1.Grb, bus1.Gra, bus1.IRin, bus1.MDRout, bus1.MDRin, bus1.Read, bus1.PCin,
                 bus1.ZLowout, bus1.ZLowIn, bus1.ZHighIn, bus1.IncPC, bus1.MARin, bus1.PCout};
  assign obs2 = {bus2.step, bus2.busy, bus2.instr_done, bus2.illegal_op,
                 bus2.RAM_write_en, bus2.Rout, bus2.R_in, bus2.Cout, bus2.Yin, bus2.BAout,
                 bus2.Grb, bus2.Gra, bus2.IRin, bus2.MDRout, bus2.MDRin, bus2.Read, bus2.PCin,
                 bus2.ZLowout, bus2.ZLowIn, bus2.ZHighIn, bus2.IncPC, bus2.MARin, bus2.PCout};
  assign obs_sel = (sel == 0) ? obs0 : (sel == 1) ? obs1 : obs2;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [18:0] S(int i);
    logic [18:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  // {step, busy, instr_done, illegal_op, strobes}
  function automatic logic [25:0] ev(int step, logic done, logic ill, logic [18:0] st);
    return {4'(step), (step != 0), done, ill, st};
  endfunction

  // Expected per-cycle trace of one unstalled instruction, straight from the step table.
  function automatic void build(int k, int w);
    plan.delete();
    plan.push_back(ev(1, 1'b0, 1'b0, S(B_PCOUT) | S(B_MARIN) | S(B_INCPC) | S(B_ZHI) | S(B_ZLI)));
    for (int i = 0; i <= w; i++)
      plan.push_back(ev(2, 1'b0, 1'b0, S(B_READ) | ((i == w) ? (S(B_MDRIN) | S(B_ZLO) | S(B_PCIN)) : 19'b0)));
    plan.push_back(ev(3, 1'b0, 1'b0, S(B_MDROUT) | S(B_IRIN)));
    if (k == K_ILL) begin
      plan.push_back(ev(4, 1'b0, 1'b1, 19'b0));
      return;
    end
    plan.push_back(ev(4, 1'b0, 1'b0, S(B_GRB) | S(B_BAOUT) | S(B_YIN)));
    plan.push_back(ev(5, 1'b0, 1'b0, S(B_COUT) | S(B_ZHI) | S(B_ZLI)));
    if (k == K_LDI) begin
      plan.push_back(ev(6, 1'b1, 1'b0, S(B_ZLO) | S(B_GRA) | S(B_RIN)));
      return;
    end
    plan.push_back(ev(6, 1'b0, 1'b0, S(B_ZLO) | S(B_MARIN)));
    if (k == K_LD) begin
      for (int i = 0; i <= w; i++)
        plan.push_back(ev(7, 1'b0, 1'b0, S(B_READ) | ((i == w) ? S(B_MDRIN) : 19'b0)));
      plan.push_back(ev(8, 1'b1, 1'b0, S(B_MDROUT) | S(B_GRA) | S(B_RIN)));
    end else begin
      plan.push_back(ev(7, 1'b0, 1'b0, S(B_GRA) | S(B_ROUT) | S(B_MDRIN)));
      for (int i = 0; i <= w; i++)
        plan.push_back(ev(8, (i == w), 1'b0, S(B_RAM)));
    end
  endfunction

  // Apply one cycle of stimulus to DUT d and queue what it must show this cycle.
  task automatic drive(int d, logic r, logic s, logic [4:0] o, logic c, logic [25:0] e);
    for (int i = 0; i < 3; i++) begin
      run_v[i]   = 1'b0;
      stall_v[i] = 1'b0;
      opc_v[i]   = 5'd0;
    end
    sel        = d;
    run_v[d]   = r;
    stall_v[d] = s;
    opc_v[d]   = o;
    clr        = c;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int d);
    drive(d, 1'b0, 1'b0, 5'($urandom), 1'b0, ev(0, 1'b0, 1'b0, 19'b0));
  endtask

  // Opcode is only meaningful in T3; other cycles carry junk to prove it is latched.
  task automatic run_instr(int d, int k, logic [4:0] opc, int w, logic from_idle,
                           logic rn, int stall_at, int stall_n);
    logic [25:0] e;
    logic [4:0]  o;
    build(k, w);
    if (from_idle) drive(d, 1'b1, 1'b0, 5'($urandom), 1'b0, ev(0, 1'b0, 1'b0, 19'b0));
    for (int i = 0; i < plan.size(); i++) begin
      e = plan[i];
      o = (e[25:22] == 4'd4) ? opc : 5'($urandom);
      if (i == stall_at)
        for (int j = 0; j < stall_n; j++)
          drive(d, rn, 1'b1, o, 1'b0, ev(int'(e[25:22]), 1'b0, 1'b0, 19'b0));
      drive(d, rn, 1'b0, o, 1'b0, e);
    end
  endtask

  task automatic clr_case(int d, int w, logic with_stall);
    logic [25:0] e;
    build(K_LD, w);
    drive(d, 1'b1, 1'b0, 5'($urandom), 1'b0, ev(0, 1'b0, 1'b0, 19'b0));
    for (int i = 0; i < plan.size(); i++) begin
      e = plan[i];
      if (e[25:22] == 4'd5) begin
        drive(d, 1'b1, with_stall, 5'($urandom), 1'b1,
              with_stall ? ev(5, 1'b0, 1'b0, 19'b0) : e);
        break;
      end
      drive(d, 1'b0, 1'b0, (e[25:22] == 4'd4) ? 5'b00000 : 5'($urandom), 1'b0, e);
    end
    drive(d, 1'b1, 1'b0, 5'($urandom), 1'b0, ev(0, 1'b0, 1'b0, 19'b0));
    drive(d, 1'b0, 1'b0, 5'($urandom), 1'b0, plan[0]);
    drive(d, 1'b0, 1'b0, 5'($urandom), 1'b1, plan[1]);
    idle(d);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      e_mon = exp_q.pop_front();
      check($sformatf("dut%0d_step%0d", sel, e_mon[25:22]), 32'(obs_sel), 32'(e_mon));
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    clr = 1'b1;
    sel = 0;
    for (int i = 0; i < 3; i++) begin
      run_v[i] = 1'b0; stall_v[i] = 1'b0; opc_v[i] = 5'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) drive(d, 1'b1, 1'b0, 5'd0, 1'b1, ev(0, 1'b0, 1'b0, 19'b0));

    // ld, no wait states, run pulsed for one cycle
    run_instr(0, K_LD, 5'b00000, 0, 1'b1, 1'b0, -1, 0); idle(0);
    // st with two wait states
    run_instr(2, K_ST, 5'b00010, 2, 1'b1, 1'b0, -1, 0); idle(2);
    // ldi with run held, followed immediately by ld
    run_instr(0, K_LDI, 5'b00001, 0, 1'b1, 1'b1, -1, 0);
    run_instr(0, K_LD, 5'b00000, 0, 1'b0, 1'b0, -1, 0); idle(0);
    // illegal with run=1 continues to ldi; illegal with run=0 returns to IDLE
    run_instr(0, K_ILL, 5'b11111, 0, 1'b1, 1'b1, -1, 0);
    run_instr(0, K_LDI, 5'b00001, 0, 1'b0, 1'b0, -1, 0); idle(0);
    run_instr(1, K_ILL, 5'b00101, 1, 1'b1, 1'b0, -1, 0); idle(1);
    // stalls: 3 cycles inside T6 of ld, 2 cycles on T3 of st
    run_instr(1, K_LD, 5'b00000, 1, 1'b1, 1'b0, 8, 3); idle(1);
    run_instr(1, K_ST, 5'b00010, 1, 1'b1, 1'b0, 4, 2); idle(1);
    run_instr(2, K_LD, 5'b00000, 2, 1'b1, 1'b0, 3, 1); idle(2);
    // clr in T4, plain and together with stall
    clr_case(0, 0, 1'b0);
    clr_case(2, 2, 1'b1);

    check("drain", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
